regfile_mp: RTL
===============

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-read-port register file for the single-cycle CPU datapath.
//  Provides NUM_RD asynchronous read ports, one general write port, and a dedicated link write port (jal return address).
//  Supports a synchronous sequential clear after reset and optional write-to-read bypass.
//  Sits between decode (rs/rt addresses) and ALU/memory writeback (busW), replacing the fixed 2R1W file.
// PARAMETERS
//  DW       32  data width in bits
//  DEPTH    32  number of registers (power of 2, >=4); AW = $clog2(DEPTH)
//  NUM_RD   2   number of read ports (>=1)
//  LINK_IDX 31  register index written by the link port (must be nonzero, < DEPTH)
// PORTS
//  clk       in   1          rising-edge clock
//  rst       in   1          synchronous reset, active-high
//  ready     out  1          1 = file cleared and accepting writes
//  rd_addr   in   NUM_RD*AW  packed read addresses, port i at [i*AW +: AW]
//  rd_data   out  NUM_RD*DW  packed read data, port i at [i*DW +: DW]
//  wr_en     in   1          general write enable
//  wr_addr   in   AW         general write address (rd or rt)
//  wr_data   in   DW         general write data (busW)
//  lnk_we    in   1          link write enable (jal)
//  lnk_data  in   DW         link value (PC+4 from IFU)
// BEHAVIOUR
//  - State machine: states CLEAR and RUN, with clear pointer clr_ptr[AW-1:0].
//  - Any edge with rst=1: state<=CLEAR, clr_ptr<=1, ready<=0. Register contents are not touched on that edge.
//  - CLEAR, rst=0: each edge writes reg[clr_ptr]<=0 and increments clr_ptr.
//    - The edge that clears DEPTH-1 sets state<=RUN and ready<=1.
//    - ready therefore rises DEPTH-1 edges after rst deasserts.
//  - rst asserted mid-CLEAR restarts the sweep at 1. rst mid-RUN drops ready and re-clears all entries.
//  - In CLEAR, wr_en and lnk_we are ignored (dropped, not queued), and all rd_data read 0.
//  - RUN: on a clk edge, wr_en=1 writes reg[wr_addr]<=wr_data, and lnk_we=1 writes reg[LINK_IDX]<=lnk_data.
//  - Both writes target LINK_IDX in the same cycle: the link port wins; wr_data is discarded.
//  - Register 0 reads 0 always. Writes to 0 are ignored on both paths; reg 0 is not stored.
//  - Reads are combinational: rd_data[i] = reg[rd_addr[i]] with zero cycles of latency.
//  - Any number of ports may read the same address.
//  - No arithmetic on data. clr_ptr wraps are impossible because the sweep stops at DEPTH-1.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined:
//    - In RUN, a read whose address matches a same-cycle enabled write returns the write data combinationally.
//    - Link data has priority over wr_data when both match. Address 0 is never bypassed.
//  REGFILE_BYPASS_EN undefined:
//    - Reads return stored contents only; a write is visible from the cycle after its edge.
// STRUCTURE
//  - Package regfile_pkg holds:
//    - state encoding localparams (ST_CLEAR=1'b0, ST_RUN=1'b1);
//    - REG_ZERO=0 and the default LINK_IDX=31;
//    - a function for the packed-slice index.
//  - One sub-module, regfile_clear_ctrl, owns the CLEAR/RUN FSM, clr_ptr and ready.
//    - It outputs clr_we and clr_addr to the storage array.
//  - Storage array, write arbitration and read muxes live in regfile_mp.
// TESTING (DEPTH=32, DW=32, NUM_RD=2)
//  1. rst high 1 cycle, then low:
//     - ready=0 for 30 edges, ready=1 after the 31st;
//     - rd_data=0 on both ports for all 32 addresses.
//  2. RUN, wr_en=1, wr_addr=5, wr_data=0xDEADBEEF, rd_addr[0]=5:
//     - same cycle reads the old value 0 (0xDEADBEEF with BYPASS_EN);
//     - next cycle reads 0xDEADBEEF.
//  3. wr_en=1, wr_addr=0, wr_data=0xFFFFFFFF -> rd_data for address 0 is 0 forever after, with BYPASS_EN too.
//  4. Same edge: wr_en=1, wr_addr=31, wr_data=0x1111 and lnk_we=1, lnk_data=0x2222 -> reg31 reads 0x00002222.
//  5. Write 0xA5A5A5A5 to regs 1..31, then pulse rst during RUN:
//     - ready drops next edge;
//     - after the sweep, all reads are 0.
//  6. During CLEAR, wr_en=1, wr_addr=7, wr_data=0x77, plus lnk_we=1 -> after ready=1, regs 7 and 31 both read 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package regfile_pkg;

  // Sweep/run state encoding for the clear controller
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } regState_t;

  // Register 0 is hardwired to zero and never stored
  localparam int REG_ZERO = 0;

  // Default destination of the link (jal return address) write
  localparam int LINK_IDX_DEF = 31;

  // Low bit of element idx inside a packed vector of width-bit elements
  function automatic int sliceLo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/regfile_clear_ctrl.sv
// Sequential post-reset clear sweep over entries 1..DEPTH-1, then RUN with ready high.
// Latency: one entry cleared per clock; ready rises DEPTH-1 edges after rst deasserts.
// Backpressure: none; writes are simply dropped by the file while ready is low.
module regfile_clear_ctrl
  import regfile_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          ready,
  output logic          clrWe,
  output logic [AW-1:0] clrAddr
);

  regState_t       state;
  logic [AW-1:0]   clrPtr;

  // Sweep FSM: reset restarts at entry 1, last entry hands over to RUN
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_CLEAR;
      clrPtr <= AW'(1);
      ready  <= 1'b0;
    end else if (state == ST_CLEAR) begin
      if (clrPtr == AW'(DEPTH - 1)) begin
        state <= ST_RUN;
        ready <= 1'b1;
      end else begin
        clrPtr <= clrPtr + AW'(1);
      end
    end
  end

  // The reset edge itself must not touch storage, hence the rst qualifier
  assign clrWe   = (state == ST_CLEAR) && !rst;
  assign clrAddr = clrPtr;

endmodule

// File: rtl/regfile_mp.sv
// NUM_RD async read / general + link write register file with post-reset clear sweep.
// Latency: reads combinational; writes visible the cycle after their edge (same cycle with REGFILE_BYPASS_EN).
// Backpressure: none; writes arriving while ready is low are dropped, reads return 0 until ready.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DW       = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int LINK_IDX = LINK_IDX_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  output logic                              ready,
  input  logic [NUM_RD*$clog2(DEPTH)-1:0]   rd_addr,
  output logic [NUM_RD*DW-1:0]              rd_data,
  input  logic                              wr_en,
  input  logic [$clog2(DEPTH)-1:0]          wr_addr,
  input  logic [DW-1:0]                     wr_data,
  input  logic                              lnk_we,
  input  logic [DW-1:0]                     lnk_data
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW-1:0] LinkAddr = AW'(LINK_IDX);
  localparam logic [AW-1:0] ZeroAddr = AW'(REG_ZERO);

  // Entry 0 has no storage; it always reads as zero
  logic [DW-1:0] mem [1:DEPTH-1];

  logic          clrWe;
  logic [AW-1:0] clrAddr;
  logic          runActive;
  logic          lnkWrite;
  logic          genWrite;

  regfile_clear_ctrl #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) uClearCtrl (
    .clk     (clk),
    .rst     (rst),
    .ready   (ready),
    .clrWe   (clrWe),
    .clrAddr (clrAddr)
  );

  // Writes only land in RUN and never on a reset edge; writes to entry 0 are discarded
  assign runActive = ready && !rst;
  assign lnkWrite  = runActive && lnk_we;
  assign genWrite  = runActive && wr_en && (wr_addr != ZeroAddr);

  // Storage update: clear sweep, then link port, then general port (link wins a collision)
  always_ff @(posedge clk) begin
    for (int j = 1; j < DEPTH; j++) begin
      if (clrWe && (clrAddr == AW'(j))) begin
        mem[j] <= '0;
      end else if (lnkWrite && (LinkAddr == AW'(j))) begin
        mem[j] <= lnk_data;
      end else if (genWrite && (wr_addr == AW'(j))) begin
        mem[j] <= wr_data;
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : gRead
    logic [AW-1:0] rdAddr;
    logic [DW-1:0] rdVal;

    assign rdAddr = rd_addr[sliceLo(p, AW) +: AW];

    // Read mux per port; forced to zero during the clear sweep
    always_comb begin
      rdVal = '0;
      for (int j = 1; j < DEPTH; j++) begin
        if (rdAddr == AW'(j)) begin
          rdVal = mem[j];
        end
      end
`ifdef REGFILE_BYPASS_EN
      // Forward same-cycle writes; address 0 can never match since neither path writes it
      if (lnkWrite && (rdAddr == LinkAddr)) begin
        rdVal = lnk_data;
      end else if (genWrite && (rdAddr == wr_addr)) begin
        rdVal = wr_data;
      end
`endif
      if (!ready) begin
        rdVal = '0;
      end
    end

    assign rd_data[sliceLo(p, DW) +: DW] = rdVal;
  end

endmodule
